// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with operand forwarding, load-use detection, stall/flush/bubble control
module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            id_valid_i,
    output logic            id_ready_o,
    input  logic [XLEN-1:0] id_pc_i,
    input  logic [XLEN-1:0] id_rs1_data_i,
    input  logic [XLEN-1:0] id_rs2_data_i,
    input  logic [XLEN-1:0] id_imm_i,
    input  logic [RA_W-1:0] id_rs1_addr_i,
    input  logic [RA_W-1:0] id_rs2_addr_i,
    input  logic [RA_W-1:0] id_rd_addr_i,
    input  logic            id_use_rs1_i,
    input  logic            id_use_rs2_i,
    input  logic [3:0]      id_alu_op_i,
    input  logic [1:0]      id_src_a_sel_i,
    input  logic            id_src_b_sel_i,
    input  logic            id_reg_write_i,
    input  logic            id_mem_read_i,
    input  logic            id_mem_write_i,
    input  logic            ex_stall_i,
    input  logic            flush_i,
    input  logic            exm_reg_write_i,
    input  logic [RA_W-1:0] exm_rd_addr_i,
    input  logic [XLEN-1:0] exm_result_i,
    input  logic            mwb_reg_write_i,
    input  logic [RA_W-1:0] mwb_rd_addr_i,
    input  logic [XLEN-1:0] mwb_result_i,
    output logic            ex_valid_o,
    output logic [XLEN-1:0] alu_operand_a_o,
    output logic [XLEN-1:0] alu_operand_b_o,
    output logic [3:0]      alu_op_o,
    output logic [XLEN-1:0] ex_store_data_o,
    output logic [XLEN-1:0] ex_pc_o,
    output logic [RA_W-1:0] ex_rd_addr_o,
    output logic            ex_reg_write_o,
    output logic            ex_mem_read_o,
    output logic            ex_mem_write_o,
    output logic            load_use_stall_o
);

    logic            valid_q, valid_d;
    logic [XLEN-1:0] pc_q, pc_d, rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d, imm_q, imm_d;
    logic [RA_W-1:0] rs1_addr_q, rs1_addr_d, rs2_addr_q, rs2_addr_d, rd_addr_q, rd_addr_d;
    logic            use_rs1_q, use_rs1_d, use_rs2_q, use_rs2_d;
    logic [3:0]      alu_op_q, alu_op_d;
    logic [1:0]      src_a_q, src_a_d;
    logic            src_b_q, src_b_d;
    logic            reg_write_q, reg_write_d, mem_read_q, mem_read_d, mem_write_q, mem_write_d;
    logic [XLEN-1:0] fwd_rs1, fwd_rs2;

    // Forwarding: EX/MEM beats MEM/WB, x0 never forwards
    always_comb begin
        fwd_rs1 = (exm_reg_write_i && exm_rd_addr_i == rs1_addr_q && rs1_addr_q != '0) ? exm_result_i :
                  (mwb_reg_write_i && mwb_rd_addr_i == rs1_addr_q && rs1_addr_q != '0) ? mwb_result_i : rs1_data_q;
        fwd_rs2 = (exm_reg_write_i && exm_rd_addr_i == rs2_addr_q && rs2_addr_q != '0) ? exm_result_i :
                  (mwb_reg_write_i && mwb_rd_addr_i == rs2_addr_q && rs2_addr_q != '0) ? mwb_result_i : rs2_data_q;
    end

    // ALU operand selection, hazard detection and valid-gated controls
    always_comb begin
        alu_operand_a_o  = (src_a_q == 2'b00) ? fwd_rs1 : (src_a_q == 2'b01) ? pc_q : '0;
        alu_operand_b_o  = src_b_q ? imm_q : fwd_rs2;
        ex_store_data_o  = fwd_rs2;
        alu_op_o         = alu_op_q;
        ex_pc_o          = pc_q;
        ex_rd_addr_o     = rd_addr_q;
        ex_valid_o       = valid_q;
        ex_reg_write_o   = valid_q & reg_write_q;
        ex_mem_read_o    = valid_q & mem_read_q;
        ex_mem_write_o   = valid_q & mem_write_q;
        load_use_stall_o = ex_valid_o & ex_mem_read_o & (rd_addr_q != '0) & id_valid_i &
                           ((id_use_rs1_i & (id_rs1_addr_i == rd_addr_q)) |
                            (id_use_rs2_i & (id_rs2_addr_i == rd_addr_q)));
        id_ready_o       = !ex_stall_i & !load_use_stall_o & !flush_i;
    end

    // Next state: flush, then stall (refresh operand data), then bubble, then capture
    always_comb begin
        valid_d     = valid_q;
        pc_d        = pc_q;
        rs1_data_d  = rs1_data_q;
        rs2_data_d  = rs2_data_q;
        imm_d       = imm_q;
        rs1_addr_d  = rs1_addr_q;
        rs2_addr_d  = rs2_addr_q;
        rd_addr_d   = rd_addr_q;
        use_rs1_d   = use_rs1_q;
        use_rs2_d   = use_rs2_q;
        alu_op_d    = alu_op_q;
        src_a_d     = src_a_q;
        src_b_d     = src_b_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        if (flush_i || (!ex_stall_i && load_use_stall_o)) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
        end else if (ex_stall_i) begin
            rs1_data_d = fwd_rs1;
            rs2_data_d = fwd_rs2;
        end else begin
            valid_d     = id_valid_i;
            pc_d        = id_pc_i;
            rs1_data_d  = id_rs1_data_i;
            rs2_data_d  = id_rs2_data_i;
            imm_d       = id_imm_i;
            rs1_addr_d  = id_rs1_addr_i;
            rs2_addr_d  = id_rs2_addr_i;
            rd_addr_d   = id_rd_addr_i;
            use_rs1_d   = id_use_rs1_i;
            use_rs2_d   = id_use_rs2_i;
            alu_op_d    = id_alu_op_i;
            src_a_d     = id_src_a_sel_i;
            src_b_d     = id_src_b_sel_i;
            reg_write_d = id_reg_write_i;
            mem_read_d  = id_mem_read_i;
            mem_write_d = id_mem_write_i;
        end
    end

    // Stage registers, cleared asynchronously
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q     <= 1'b0;
            pc_q        <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            rs1_addr_q  <= '0;
            rs2_addr_q  <= '0;
            rd_addr_q   <= '0;
            use_rs1_q   <= 1'b0;
            use_rs2_q   <= 1'b0;
            alu_op_q    <= '0;
            src_a_q     <= '0;
            src_b_q     <= 1'b0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            rs1_data_q  <= rs1_data_d;
            rs2_data_q  <= rs2_data_d;
            imm_q       <= imm_d;
            rs1_addr_q  <= rs1_addr_d;
            rs2_addr_q  <= rs2_addr_d;
            rd_addr_q   <= rd_addr_d;
            use_rs1_q   <= use_rs1_d;
            use_rs2_q   <= use_rs2_d;
            alu_op_q    <= alu_op_d;
            src_a_q     <= src_a_d;
            src_b_q     <= src_b_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: scoreboard bench for the ID/EX stage
module tb_id_ex_stage;

    logic        clk_i = 1'b0, rst_ni = 1'b0;
    logic        id_valid_i, id_ready_o, id_use_rs1_i, id_use_rs2_i, id_src_b_sel_i;
    logic [31:0] id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i;
    logic [4:0]  id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i;
    logic [3:0]  id_alu_op_i;
    logic [1:0]  id_src_a_sel_i;
    logic        id_reg_write_i, id_mem_read_i, id_mem_write_i, ex_stall_i, flush_i;
    logic        exm_reg_write_i, mwb_reg_write_i;
    logic [4:0]  exm_rd_addr_i, mwb_rd_addr_i;
    logic [31:0] exm_result_i, mwb_result_i;
    logic        ex_valid_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, load_use_stall_o;
    logic [31:0] alu_operand_a_o, alu_operand_b_o, ex_store_data_o, ex_pc_o;
    logic [3:0]  alu_op_o;
    logic [4:0]  ex_rd_addr_o;

    int n_chk = 0, n_pass = 0;

    typedef struct packed {
        logic [31:0] a, b, st;
        logic [3:0]  op;
        logic        v, rw, mr;
    } exp_t;
    exp_t sb[$];

    id_ex_stage dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .id_valid_i(id_valid_i), .id_ready_o(id_ready_o),
        .id_pc_i(id_pc_i), .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i),
        .id_imm_i(id_imm_i), .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i),
        .id_rd_addr_i(id_rd_addr_i), .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i),
        .id_alu_op_i(id_alu_op_i), .id_src_a_sel_i(id_src_a_sel_i), .id_src_b_sel_i(id_src_b_sel_i),
        .id_reg_write_i(id_reg_write_i), .id_mem_read_i(id_mem_read_i), .id_mem_write_i(id_mem_write_i),
        .ex_stall_i(ex_stall_i), .flush_i(flush_i),
        .exm_reg_write_i(exm_reg_write_i), .exm_rd_addr_i(exm_rd_addr_i), .exm_result_i(exm_result_i),
        .mwb_reg_write_i(mwb_reg_write_i), .mwb_rd_addr_i(mwb_rd_addr_i), .mwb_result_i(mwb_result_i),
        .ex_valid_o(ex_valid_o), .alu_operand_a_o(alu_operand_a_o), .alu_operand_b_o(alu_operand_b_o),
        .alu_op_o(alu_op_o), .ex_store_data_o(ex_store_data_o), .ex_pc_o(ex_pc_o),
        .ex_rd_addr_o(ex_rd_addr_o), .ex_reg_write_o(ex_reg_write_o), .ex_mem_read_o(ex_mem_read_o),
        .ex_mem_write_o(ex_mem_write_o), .load_use_stall_o(load_use_stall_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic expect_ex(input logic [31:0] a, input logic [31:0] b, input logic [31:0] st,
                             input logic [3:0] op, input logic v, input logic rw, input logic mr);
        sb.push_back('{a: a, b: b, st: st, op: op, v: v, rw: rw, mr: mr});
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            check_eq({tag, " scoreboard empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        check_eq({tag, " a"}, alu_operand_a_o, e.a);
        check_eq({tag, " b"}, alu_operand_b_o, e.b);
        check_eq({tag, " store"}, ex_store_data_o, e.st);
        check_eq({tag, " op"}, {28'd0, alu_op_o}, {28'd0, e.op});
        check_eq({tag, " valid"}, {31'd0, ex_valid_o}, {31'd0, e.v});
        check_eq({tag, " rw"}, {31'd0, ex_reg_write_o}, {31'd0, e.rw});
        check_eq({tag, " mr"}, {31'd0, ex_mem_read_o}, {31'd0, e.mr});
    endtask

    task automatic clear_fwd;
        exm_reg_write_i = 1'b0; exm_rd_addr_i = '0; exm_result_i = '0;
        mwb_reg_write_i = 1'b0; mwb_rd_addr_i = '0; mwb_result_i = '0;
    endtask

    task automatic drive_id(input logic [31:0] pc, input logic [4:0] r1, input logic [31:0] d1,
                            input logic [4:0] r2, input logic [31:0] d2, input logic [31:0] imm,
                            input logic [4:0] rd, input logic u1, input logic u2, input logic [3:0] op,
                            input logic [1:0] sa, input logic sbs, input logic rw, input logic mr,
                            input logic mw);
        id_valid_i = 1'b1; id_pc_i = pc; id_rs1_addr_i = r1; id_rs1_data_i = d1;
        id_rs2_addr_i = r2; id_rs2_data_i = d2; id_imm_i = imm; id_rd_addr_i = rd;
        id_use_rs1_i = u1; id_use_rs2_i = u2; id_alu_op_i = op; id_src_a_sel_i = sa;
        id_src_b_sel_i = sbs; id_reg_write_i = rw; id_mem_read_i = mr; id_mem_write_i = mw;
    endtask

    task automatic step;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        drive_id('0, '0, '0, '0, '0, '0, '0, 0, 0, '0, '0, 0, 0, 0, 0);
        id_valid_i = 1'b0; ex_stall_i = 1'b0; flush_i = 1'b0;
        clear_fwd();
        #2;
        check_eq("rst valid", {31'd0, ex_valid_o}, 0);
        check_eq("rst a", alu_operand_a_o, 0);
        check_eq("rst op", {28'd0, alu_op_o}, 0);
        check_eq("rst ready", {31'd0, id_ready_o}, 1);
        check_eq("rst lu", {31'd0, load_use_stall_o}, 0);
        @(negedge clk_i) rst_ni = 1'b1;

        // forwarding priority
        drive_id(32'h40, 5, 32'hAAAA, 0, 0, 4, 7, 1, 0, 0, 2'b00, 1, 1, 0, 0);
        exm_reg_write_i = 1; exm_rd_addr_i = 5; exm_result_i = 32'h11;
        mwb_reg_write_i = 1; mwb_rd_addr_i = 5; mwb_result_i = 32'h22;
        expect_ex(32'h11, 4, 0, 0, 1, 1, 0);
        step(); pop_check("fwd exm");
        id_valid_i = 1'b0; exm_reg_write_i = 1'b0; #1;
        expect_ex(32'h22, 4, 0, 0, 1, 1, 0);
        pop_check("fwd mwb");
        drive_id(32'h44, 0, 32'h55, 0, 0, 8, 9, 1, 0, 0, 2'b00, 1, 1, 0, 0);
        exm_reg_write_i = 1; exm_rd_addr_i = 0; exm_result_i = 32'hDEAD;
        mwb_reg_write_i = 1; mwb_rd_addr_i = 0; mwb_result_i = 32'hDEAD;
        expect_ex(32'h55, 8, 0, 0, 1, 1, 0);
        step(); pop_check("x0 nofwd");

        // load-use: one bubble, then forward from MEM/WB
        clear_fwd();
        drive_id(32'h48, 2, 32'h100, 0, 0, 0, 6, 1, 0, 0, 2'b00, 1, 1, 1, 0);
        expect_ex(32'h100, 0, 0, 0, 1, 1, 1);
        step(); pop_check("lw");
        drive_id(32'h4C, 6, 0, 1, 32'h10, 0, 7, 1, 1, 0, 2'b00, 0, 1, 0, 0);
        #1;
        check_eq("lu hit", {31'd0, load_use_stall_o}, 1);
        check_eq("lu ready", {31'd0, id_ready_o}, 0);
        step();
        check_eq("bubble valid", {31'd0, ex_valid_o}, 0);
        check_eq("bubble mr", {31'd0, ex_mem_read_o}, 0);
        check_eq("bubble lu", {31'd0, load_use_stall_o}, 0);
        check_eq("bubble ready", {31'd0, id_ready_o}, 1);
        step();
        mwb_reg_write_i = 1; mwb_rd_addr_i = 6; mwb_result_i = 32'hCAFE; #1;
        expect_ex(32'hCAFE, 32'h10, 32'h10, 0, 1, 1, 0);
        pop_check("lu consumer");

        // stall + load-use: load held in EX
        clear_fwd();
        drive_id(32'h50, 2, 0, 0, 0, 0, 6, 1, 0, 0, 2'b00, 1, 1, 1, 0);
        step();
        drive_id(32'h54, 0, 0, 6, 0, 0, 7, 0, 1, 0, 2'b00, 0, 1, 0, 0);
        ex_stall_i = 1'b1; #1;
        check_eq("stall lu", {31'd0, load_use_stall_o}, 1);
        step();
        check_eq("stall lu held", {31'd0, ex_mem_read_o}, 1);
        check_eq("stall lu rd", {27'd0, ex_rd_addr_o}, 6);
        ex_stall_i = 1'b0;

        // stall retention of forwarded rs2
        drive_id(32'h60, 1, 0, 3, 32'h9999, 0, 8, 0, 1, 1, 2'b00, 0, 1, 0, 0);
        step(); step();
        mwb_reg_write_i = 1; mwb_rd_addr_i = 3; mwb_result_i = 32'h1234; #1;
        expect_ex(0, 32'h1234, 32'h1234, 1, 1, 1, 0);
        pop_check("stall pre");
        ex_stall_i = 1'b1;
        drive_id(32'h64, 0, 0, 0, 0, 0, 9, 0, 0, 0, 2'b00, 0, 1, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            clear_fwd(); #1;
            expect_ex(0, 32'h1234, 32'h1234, 1, 1, 1, 0);
            pop_check("stall hold");
            check_eq("stall ready", {31'd0, id_ready_o}, 0);
        end

        // flush beats stall
        flush_i = 1'b1; #1;
        check_eq("flush ready", {31'd0, id_ready_o}, 0);
        step();
        flush_i = 1'b0; ex_stall_i = 1'b0; #1;
        check_eq("flush valid", {31'd0, ex_valid_o}, 0);
        check_eq("flush rw", {31'd0, ex_reg_write_o}, 0);
        check_eq("flush mw", {31'd0, ex_mem_write_o}, 0);

        // source selects
        drive_id(32'h100, 1, 32'h777, 2, 32'h888, 32'h2000, 10, 0, 0, 0, 2'b01, 1, 1, 0, 0);
        expect_ex(32'h100, 32'h2000, 32'h888, 0, 1, 1, 0);
        step(); pop_check("auipc");
        check_eq("auipc pc", ex_pc_o, 32'h100);
        drive_id(32'h104, 0, 32'h777, 0, 0, 32'h12345000, 11, 0, 0, 0, 2'b10, 1, 1, 0, 0);
        expect_ex(0, 32'h12345000, 0, 0, 1, 1, 0);
        step(); pop_check("lui");
        drive_id(32'h108, 4, 32'h777, 0, 0, 5, 12, 1, 0, 4'd9, 2'b11, 1, 1, 0, 0);
        expect_ex(0, 5, 0, 4'd9, 1, 1, 0);
        step(); pop_check("sel reserved");

        // asynchronous reset during a stall
        id_valid_i = 1'b0; ex_stall_i = 1'b1;
        step();
        #1 rst_ni = 1'b0;
        #1;
        check_eq("arst valid", {31'd0, ex_valid_o}, 0);
        check_eq("arst b", alu_operand_b_o, 0);
        check_eq("arst op", {28'd0, alu_op_o}, 0);
        check_eq("arst pc", ex_pc_o, 0);
        check_eq("arst rw", {31'd0, ex_reg_write_o}, 0);
        check_eq("arst ready stall", {31'd0, id_ready_o}, 0);
        ex_stall_i = 1'b0; #1;
        check_eq("arst ready", {31'd0, id_ready_o}, 1);
        check_eq("sb drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
